packet_st_gen_engine: RTL and testbench
=======================================

Name: packet_st_gen_engine

Overview:
- Packet generator datapath, directly downstream of the Avalon-MM control register block.
- Consumes the NUMPKTS, PKTLENGTH and PAYLOAD register values, plus start/stop pulses decoded from writes to START/STOP.
- Emits NUMPKTS packets of PKTLENGTH bytes on an 8-bit Avalon-ST source with ready latency 0.
- Reports busy, packet count and a completion pulse back for status readback.

Parameters:
- IPG_CYCLES, 2, idle cycles inserted between consecutive packets (0 allowed = back-to-back).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- cfg_numpkts  input  8  number of packets per run (NUMPKTS register).
- cfg_pktlength  input  8  beats per packet (PKTLENGTH register).
- cfg_payload  input  8  payload seed byte (PAYLOAD register).
- start_pulse  input  1  one-cycle pulse on MM write to START.
- stop_pulse  input  1  one-cycle pulse on MM write to STOP.
- st_data  output  8  Avalon-ST data.
- st_valid  output  1  Avalon-ST valid.
- st_startofpacket  output  1  first beat of packet.
- st_endofpacket  output  1  last beat of packet.
- st_ready  input  1  sink ready, readyLatency 0.
- busy  output  1  high while state is not IDLE.
- pkts_sent  output  8  packets fully transferred in current/last run.
- done  output  1  one-cycle pulse when a run ends (normal or stopped).
- cfg_err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all counters and stop_pending cleared; all outputs 0. Applies mid-packet: packet truncated, no eop issued.
- States: IDLE, SEND, GAP.
- Config latch: on an accepted start, numpkts, pktlength and payload are latched. Later register changes have no effect until the next start.

IDLE:
- start_pulse with cfg_numpkts==0 or cfg_pktlength==0: start rejected; cfg_err=1 next cycle; remain IDLE.
- Otherwise: latch config; clear pkts_sent, beat_cnt and stop_pending; go to SEND.
- First beat is valid in the cycle after the start pulse (latency 1).
- stop_pulse in IDLE is ignored, including when it coincides with start_pulse (start is accepted).

SEND:
- st_valid=1.
- st_data = payload + beat_cnt, 8-bit wrap-around.
- st_startofpacket = (beat_cnt==0).
- st_endofpacket = (beat_cnt==pktlength-1).
- Handshake: a beat transfers when st_valid && st_ready. While st_ready=0, data, sop and eop are held stable and valid stays high (no retraction).
- Non-eop transfer: beat_cnt++.
- Eop transfer: pkts_sent++ and beat_cnt=0, then:
  - If pkts_sent+1==numpkts or stop_pending: go to IDLE; done=1 in the next cycle.
  - Else if IPG_CYCLES==0: stay in SEND; the next sop is presented in the following cycle.
  - Else: go to GAP.
- start_pulse in SEND or GAP is ignored (no cfg_err).

stop_pulse in SEND:
- Sets stop_pending. The current packet is completed in full (no truncation), then the run ends as above.

GAP:
- st_valid=0; gap counter runs for exactly IPG_CYCLES cycles, then back to SEND.
- stop_pulse in GAP: go to IDLE next cycle, with done=1 in that cycle.

Output rules:
- sop/eop are 0 whenever st_valid=0.
- pktlength==1: sop and eop are both asserted on the single beat.
- pkts_sent holds its final value after the run until the next accepted start.
- busy = (state != IDLE).
- done and cfg_err never both assert in the same cycle.

Test Plan:
1. numpkts=2, pktlength=4, payload=8'h10, IPG=2, ready=1 → data 10,11,12,13 (sop on 10, eop on 13); 2 idle cycles; repeat; done pulses once; pkts_sent=2; busy falls with done.
2. payload=8'hFE, pktlength=3 → data FE,FF,00 (wrap-around); backpressure (ready low 3 cycles on 2nd beat) holds data=FF with valid high, no duplicate or skipped beat.
3. numpkts=5, pktlength=6; stop_pulse on beat 2 of packet 2 → packet 2 completes with eop; no packet 3; pkts_sent=2; done=1.
4. start with pktlength=0, and separately with numpkts=0 → cfg_err pulse, busy stays 0, st_valid never asserts.
5. pktlength=1, numpkts=3, IPG=0 → three consecutive beats, each with sop=eop=1; pkts_sent=3.
6. reset_n dropped mid-packet → outputs 0 asynchronously; after release and a new start, pkts_sent restarts at 0 and the first beat carries sop.

Source files
------------

// File: rtl/packet_st_gen_engine.sv
// rtl/packet_st_gen_engine.sv - register-configured Avalon-ST packet generator
module packet_st_gen_engine #(
    parameter int unsigned IPG_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cfg_numpkts,
    input  logic [7:0] cfg_pktlength,
    input  logic [7:0] cfg_payload,
    input  logic       start_pulse,
    input  logic       stop_pulse,
    output logic [7:0] st_data,
    output logic       st_valid,
    output logic       st_startofpacket,
    output logic       st_endofpacket,
    input  logic       st_ready,
    output logic       busy,
    output logic [7:0] pkts_sent,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Terminal value of the gap counter; unused when packets go back-to-back.
    localparam int unsigned GAP_LAST_I = (IPG_CYCLES > 0) ? IPG_CYCLES - 1 : 0;
    localparam logic [7:0]  GAP_LAST   = GAP_LAST_I[7:0];

    state_t     state_q, state_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] pkts_sent_q, pkts_sent_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       stop_pending_q, stop_pending_d;
    logic [7:0] numpkts_q, numpkts_d;
    logic [7:0] pktlength_q, pktlength_d;
    logic [7:0] payload_q, payload_d;
    logic       done_q, done_d;
    logic       cfg_err_q, cfg_err_d;
    logic [7:0] st_data_q, st_data_d;
    logic       st_valid_q, st_valid_d;
    logic       st_sop_q, st_sop_d;
    logic       st_eop_q, st_eop_d;
    logic       xfer;

    // Next-state and next-output computation; outputs are derived from the
    // next state so the stream signals leave the block straight from flops.
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        pkts_sent_d    = pkts_sent_q;
        gap_cnt_d      = gap_cnt_q;
        stop_pending_d = stop_pending_q;
        numpkts_d      = numpkts_q;
        pktlength_d    = pktlength_q;
        payload_d      = payload_q;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;
        xfer           = st_valid_q && st_ready;

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    if ((cfg_numpkts == 8'd0) || (cfg_pktlength == 8'd0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        numpkts_d      = cfg_numpkts;
                        pktlength_d    = cfg_pktlength;
                        payload_d      = cfg_payload;
                        pkts_sent_d    = 8'd0;
                        beat_cnt_d     = 8'd0;
                        stop_pending_d = 1'b0;
                        state_d        = SEND;
                    end
                end
            end
            SEND: begin
                if (stop_pulse) begin
                    stop_pending_d = 1'b1;
                end
                if (xfer) begin
                    if (st_eop_q) begin
                        pkts_sent_d = pkts_sent_q + 8'd1;
                        beat_cnt_d  = 8'd0;
                        gap_cnt_d   = 8'd0;
                        // A stop arriving on the eop beat itself still ends the run here.
                        if ((pkts_sent_q + 8'd1 == numpkts_q) || stop_pending_q || stop_pulse) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (IPG_CYCLES == 0) begin
                            state_d = SEND;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            GAP: begin
                if (stop_pulse) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        st_valid_d = (state_d == SEND);
        st_data_d  = st_valid_d ? (payload_d + beat_cnt_d) : 8'd0;
        st_sop_d   = st_valid_d && (beat_cnt_d == 8'd0);
        st_eop_d   = st_valid_d && (beat_cnt_d == pktlength_d - 8'd1);
    end

    // State, counters, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            beat_cnt_q     <= 8'd0;
            pkts_sent_q    <= 8'd0;
            gap_cnt_q      <= 8'd0;
            stop_pending_q <= 1'b0;
            numpkts_q      <= 8'd0;
            pktlength_q    <= 8'd0;
            payload_q      <= 8'd0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            st_data_q      <= 8'd0;
            st_valid_q     <= 1'b0;
            st_sop_q       <= 1'b0;
            st_eop_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            pkts_sent_q    <= pkts_sent_d;
            gap_cnt_q      <= gap_cnt_d;
            stop_pending_q <= stop_pending_d;
            numpkts_q      <= numpkts_d;
            pktlength_q    <= pktlength_d;
            payload_q      <= payload_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
            st_data_q      <= st_data_d;
            st_valid_q     <= st_valid_d;
            st_sop_q       <= st_sop_d;
            st_eop_q       <= st_eop_d;
        end
    end

    assign st_data          = st_data_q;
    assign st_valid         = st_valid_q;
    assign st_startofpacket = st_sop_q;
    assign st_endofpacket   = st_eop_q;
    assign busy             = (state_q != IDLE);
    assign pkts_sent        = pkts_sent_q;
    assign done             = done_q;
    assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_packet_st_gen_engine.sv
// tb/tb_packet_st_gen_engine.sv - scoreboard bench for packet_st_gen_engine
module tb_packet_st_gen_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] cfg_numpkts   [2];
    logic [7:0] cfg_pktlength [2];
    logic [7:0] cfg_payload   [2];
    logic       start_pulse   [2];
    logic       stop_pulse    [2];
    logic       st_ready      [2];
    logic [7:0] st_data       [2];
    logic       st_valid      [2];
    logic       st_sop        [2];
    logic       st_eop        [2];
    logic       busy          [2];
    logic [7:0] pkts_sent     [2];
    logic       done          [2];
    logic       cfg_err       [2];

    int checks = 0;
    int failures = 0;
    int done_cnt  [2];
    int err_cnt   [2];
    int valid_cnt [2];
    int exp_pkts  [2];
    bit rdy_rand  [2];

    // Lane 0: default inter-packet gap; lane 1: back-to-back packets.
    packet_st_gen_engine #(.IPG_CYCLES(2)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cfg_numpkts(cfg_numpkts[0]), .cfg_pktlength(cfg_pktlength[0]), .cfg_payload(cfg_payload[0]),
        .start_pulse(start_pulse[0]), .stop_pulse(stop_pulse[0]),
        .st_data(st_data[0]), .st_valid(st_valid[0]),
        .st_startofpacket(st_sop[0]), .st_endofpacket(st_eop[0]), .st_ready(st_ready[0]),
        .busy(busy[0]), .pkts_sent(pkts_sent[0]), .done(done[0]), .cfg_err(cfg_err[0])
    );

    packet_st_gen_engine #(.IPG_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cfg_numpkts(cfg_numpkts[1]), .cfg_pktlength(cfg_pktlength[1]), .cfg_payload(cfg_payload[1]),
        .start_pulse(start_pulse[1]), .stop_pulse(stop_pulse[1]),
        .st_data(st_data[1]), .st_valid(st_valid[1]),
        .st_startofpacket(st_sop[1]), .st_endofpacket(st_eop[1]), .st_ready(st_ready[1]),
        .busy(busy[1]), .pkts_sent(pkts_sent[1]), .done(done[1]), .cfg_err(cfg_err[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Per-lane monitor: pops one expected beat {first_of_run, sop, eop, data} per transfer.
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int IPG = (g == 0) ? 2 : 0;
        logic [10:0] exp_q[$];
        int          idle_run = 0;
        bit          prev_stall = 1'b0;
        logic [9:0]  prev_beat = '0;

        always @(negedge clk) begin
            logic [10:0] e;
            if (!reset_n) begin
                idle_run   = 0;
                prev_stall = 1'b0;
            end else begin
                chk("done_err_excl", int'(done[g] & cfg_err[g]), 0);
                if (prev_stall) begin
                    chk("stall_valid", int'(st_valid[g]), 1);
                    chk("stall_hold", int'({st_sop[g], st_eop[g], st_data[g]}), int'(prev_beat));
                end
                if (!st_valid[g]) begin
                    idle_run++;
                    chk("sop_eop_idle", int'({st_sop[g], st_eop[g]}), 0);
                end else begin
                    valid_cnt[g]++;
                    if (st_ready[g]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat lane=%0d actual_data=%0d required=none", g, st_data[g]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", int'(st_data[g]), int'(e[7:0]));
                            chk("beat_sop", int'(st_sop[g]), int'(e[9]));
                            chk("beat_eop", int'(st_eop[g]), int'(e[8]));
                            if (st_sop[g] && !e[10]) chk("ipg_len", idle_run, IPG);
                            if (st_eop[g]) idle_run = 0;
                        end
                    end
                end
                prev_stall = st_valid[g] && !st_ready[g];
                prev_beat  = {st_sop[g], st_eop[g], st_data[g]};
                if (done[g]) begin
                    done_cnt[g]++;
                    chk("busy_at_done", int'(busy[g]), 0);
                    chk("pkts_at_done", int'(pkts_sent[g]), exp_pkts[g]);
                    chk("beats_left", exp_q.size(), 0);
                end
                if (cfg_err[g]) err_cnt[g]++;
            end
        end

        // Random backpressure when enabled for this lane.
        always @(posedge clk) begin
            #1;
            if (rdy_rand[g]) st_ready[g] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push_beat(input int g, input logic [10:0] b);
        if (g == 0) lane[0].exp_q.push_back(b);
        else        lane[1].exp_q.push_back(b);
    endtask

    task automatic flush(input int g);
        if (g == 0) lane[0].exp_q.delete();
        else        lane[1].exp_q.delete();
    endtask

    // Reference: packets [0, min(n, stop_after)) each carrying pay, pay+1, ... mod 256.
    task automatic model_run(input int g, input int n, input int len, input logic [7:0] pay, input int stop_after);
        int npk;
        logic [7:0] d;
        npk = (stop_after < n) ? stop_after : n;
        for (int p = 0; p < npk; p++) begin
            for (int b = 0; b < len; b++) begin
                d = pay + 8'(b);
                push_beat(g, {(p == 0) && (b == 0), (b == 0), (b == len - 1), d});
            end
        end
        exp_pkts[g] = npk;
    endtask

    // Pulse start (optionally with stop), then scramble the config registers.
    task automatic start_run(input int g, input int n, input int len, input logic [7:0] pay, input bit with_stop);
        @(posedge clk); #1;
        cfg_numpkts[g]   = 8'(n);
        cfg_pktlength[g] = 8'(len);
        cfg_payload[g]   = pay;
        start_pulse[g]   = 1'b1;
        stop_pulse[g]    = with_stop;
        @(posedge clk); #1;
        start_pulse[g]   = 1'b0;
        stop_pulse[g]    = 1'b0;
        cfg_numpkts[g]   = 8'($urandom);
        cfg_pktlength[g] = 8'($urandom);
        cfg_payload[g]   = 8'($urandom);
    endtask

    task automatic wait_done(input int g, input int d0);
        int i = 0;
        while (done_cnt[g] == d0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        chk("run_done", done_cnt[g] - d0, 1);
        repeat (4) @(posedge clk);
        chk("done_once", done_cnt[g] - d0, 1);
    endtask

    task automatic run(input int g, input int n, input int len, input logic [7:0] pay);
        int d0 = done_cnt[g];
        model_run(g, n, len, pay, n);
        start_run(g, n, len, pay, 1'b0);
        wait_done(g, d0);
    endtask

    initial begin
        int d0, e0, v0, i;
        logic [7:0] pay, tgt;
        for (int g = 0; g < 2; g++) begin
            cfg_numpkts[g] = 8'd0; cfg_pktlength[g] = 8'd0; cfg_payload[g] = 8'd0;
            start_pulse[g] = 1'b0; stop_pulse[g] = 1'b0; st_ready[g] = 1'b1;
            done_cnt[g] = 0; err_cnt[g] = 0; valid_cnt[g] = 0; exp_pkts[g] = 0; rdy_rand[g] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_valid", int'(st_valid[g]), 0);
            chk("rst_busy", int'(busy[g]), 0);
            chk("rst_pkts", int'(pkts_sent[g]), 0);
            chk("rst_flags", int'({st_sop[g], st_eop[g], done[g], cfg_err[g]}), 0);
        end
        reset_n = 1'b1;

        // Two 4-beat packets with a 2-cycle gap.
        run(0, 2, 4, 8'h10);

        // Payload wrap plus a 3-cycle stall on the second beat.
        d0 = done_cnt[0];
        model_run(0, 1, 3, 8'hFE, 1);
        start_run(0, 1, 3, 8'hFE, 1'b0);
        @(posedge clk); #1;
        st_ready[0] = 1'b0;
        chk("bp_data", int'(st_data[0]), 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        st_ready[0] = 1'b1;
        wait_done(0, d0);

        // Stop during beat 2 of the second packet.
        pay = 8'($urandom);
        tgt = pay + 8'd2;
        d0 = done_cnt[0];
        model_run(0, 5, 6, pay, 2);
        start_run(0, 5, 6, pay, 1'b0);
        i = 0;
        while (!(pkts_sent[0] == 8'd1 && st_valid[0] && st_data[0] == tgt) && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        chk("stop_point_found", int'(i < 500), 1);
        stop_pulse[0] = 1'b1;
        @(posedge clk); #1;
        stop_pulse[0] = 1'b0;
        wait_done(0, d0);

        // Rejected starts: zero packet count, then zero length.
        d0 = done_cnt[0]; e0 = err_cnt[0]; v0 = valid_cnt[0];
        start_run(0, 0, 4, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        start_run(0, 3, 0, 8'h44, 1'b0);
        repeat (3) @(posedge clk);
        chk("cfg_err_pulses", err_cnt[0] - e0, 2);
        chk("rejected_valid", valid_cnt[0] - v0, 0);
        chk("rejected_done", done_cnt[0] - d0, 0);
        chk("rejected_busy", int'(busy[0]), 0);

        // Single-beat packets back-to-back; a coincident stop in IDLE is ignored.
        d0 = done_cnt[1];
        model_run(1, 3, 1, 8'hA5, 3);
        start_run(1, 3, 1, 8'hA5, 1'b1);
        wait_done(1, d0);

        // Asynchronous reset mid-packet, then a fresh run.
        model_run(0, 3, 8, 8'h20, 3);
        start_run(0, 3, 8, 8'h20, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(st_valid[0]), 0);
        chk("arst_busy", int'(busy[0]), 0);
        chk("arst_flags", int'({st_sop[0], st_eop[0], done[0]}), 0);
        chk("arst_pkts", int'(pkts_sent[0]), 0);
        flush(0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(0, 2, 3, 8'h7C);

        // Randomized runs with random backpressure on both lanes.
        for (int k = 0; k < 8; k++) begin
            int g = k % 2;
            rdy_rand[g] = 1'b1;
            run(g, int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 8'($urandom));
            rdy_rand[g] = 1'b0;
            @(posedge clk); #2;
            st_ready[g] = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
